// File: rtl/buffered_mesh_router.sv
// Package and router for one tile of an N x N XY mesh.
//
// router_pkg
//   packet_t   : {dest[7:0], payload[15:0]}
//   port_e     : 0=local, 1=north, 2=south, 3=east, 4=west
//
// buffered_mesh_router
//   An input FIFO per port. A round-robin arbiter and a one-entry output
//   register per output. Dimension-ordered (X then Y) routing.
//   clk         rising-edge clock
//   rst         synchronous active-low reset
//   data_in     5 x packet_t, input packets by port
//   valid_in    5, input valid by port
//   ready_out   5, input FIFO not full by port
//   data_out    5 x packet_t, registered output packets
//   valid_out   5, output register occupied
//   ready_in    5, downstream accepts data_out this cycle
//   drop_count  16, saturating count of discarded illegal-dest packets

package router_pkg;
  localparam int NUM_PORTS = 5;

  typedef struct packed {
    logic [7:0]  dest;
    logic [15:0] payload;
  } packet_t;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_SOUTH = 3'd2,
    PORT_EAST  = 3'd3,
    PORT_WEST  = 3'd4
  } port_e;
endpackage

module buffered_mesh_router
  import router_pkg::*;
#(
  parameter int ROUTER_ID  = 0,
  parameter int X          = 0,
  parameter int Y          = 0,
  parameter int N          = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  packet_t [NUM_PORTS-1:0]  data_in,
  input  logic    [NUM_PORTS-1:0]  valid_in,
  output logic    [NUM_PORTS-1:0]  ready_out,
  output packet_t [NUM_PORTS-1:0]  data_out,
  output logic    [NUM_PORTS-1:0]  valid_out,
  input  logic    [NUM_PORTS-1:0]  ready_in,
  output logic    [15:0]           drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [7:0] N_L      = 8'(N);
  localparam logic [7:0] X_L      = 8'(X);
  localparam logic [7:0] Y_L      = 8'(Y);
  localparam logic [8:0] NUM_DEST = 9'(N * N);

  // Catch mis-parameterised instances at elaboration.
  if (ROUTER_ID != Y * N + X) begin : g_bad_router_id
    $error("buffered_mesh_router: ROUTER_ID must equal Y*N+X");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("buffered_mesh_router: FIFO_DEPTH must be a power of 2, >= 2");
  end

  // ---------------------------------------------------------------------
  // Input FIFOs
  // ---------------------------------------------------------------------
  packet_t     mem    [NUM_PORTS][FIFO_DEPTH];
  logic [AW:0] wr_ptr [NUM_PORTS];
  logic [AW:0] rd_ptr [NUM_PORTS];
  packet_t     head   [NUM_PORTS];

  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      empty[p] = (wr_ptr[p] == rd_ptr[p]);
      // The extra pointer bit tells a full FIFO apart from an empty one.
      full[p]  = (wr_ptr[p][AW] != rd_ptr[p][AW]) &&
                 (wr_ptr[p][AW-1:0] == rd_ptr[p][AW-1:0]);
      head[p]  = mem[p][rd_ptr[p][AW-1:0]];
    end
  end

  // ready_out comes only from registered state, so a full FIFO refuses
  // a push even in a cycle where it pops.
  assign ready_out = ~full;
  assign push      = valid_in & ~full;

  // NOTE: storage has no reset. Only the pointers define what is valid,
  // and leaving the array unreset lets it map onto plain RAM cells.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push[p]) mem[p][wr_ptr[p][AW-1:0]] <= data_in[p];
    end
  end

  // ---------------------------------------------------------------------
  // Route computation for each FIFO head
  // ---------------------------------------------------------------------
  port_e                route   [NUM_PORTS];
  logic [NUM_PORTS-1:0] illegal;

  always_comb begin
    logic [7:0] dx;
    logic [7:0] dy;
    dx = '0;
    dy = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      dx         = head[p].dest % N_L;
      dy         = head[p].dest / N_L;
      illegal[p] = !empty[p] && ({1'b0, head[p].dest} >= NUM_DEST);
      if      (dx > X_L) route[p] = PORT_EAST;
      else if (dx < X_L) route[p] = PORT_WEST;
      else if (dy > Y_L) route[p] = PORT_NORTH;
      else if (dy < Y_L) route[p] = PORT_SOUTH;
      else               route[p] = PORT_LOCAL;
    end
  end

  // ---------------------------------------------------------------------
  // Round-robin arbitration for each output
  // ---------------------------------------------------------------------
  logic [2:0]           rr_ptr [NUM_PORTS];
  logic [NUM_PORTS-1:0] grant;
  logic [2:0]           winner [NUM_PORTS];

  always_comb begin
    logic [3:0] sum;
    logic [2:0] idx;
    logic       free;
    logic       req;
    sum   = '0;
    idx   = '0;
    free  = 1'b0;
    req   = 1'b0;
    grant = '0;
    pop   = illegal;  // an illegal head is discarded in its first cycle at head
    for (int o = 0; o < NUM_PORTS; o++) begin
      winner[o] = '0;
      free      = !valid_out[o] || ready_in[o];
      // Scan upward from rr_ptr, mod 5. The first requester found wins.
      for (int i = 0; i < NUM_PORTS; i++) begin
        sum = {1'b0, rr_ptr[o]} + 4'(i);
        idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
        req = !empty[idx] && !illegal[idx] && (route[idx] == port_e'(o));
        if (free && req && !grant[o]) begin
          grant[o]  = 1'b1;
          winner[o] = idx;
        end
      end
      // Each head has exactly one route, so at most one output pops a FIFO.
      if (grant[o]) pop[winner[o]] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Drop counter (several ports may discard in one cycle)
  // ---------------------------------------------------------------------
  logic [2:0]  drops_now;
  logic [16:0] drop_sum;

  always_comb begin
    drops_now = '0;
    for (int p = 0; p < NUM_PORTS; p++) drops_now = drops_now + 3'(illegal[p]);
    drop_sum = {1'b0, drop_count} + 17'(drops_now);
  end

  // ---------------------------------------------------------------------
  // State registers: pointers, output registers, arbiter pointers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        rr_ptr[p] <= '0;
      end
      valid_out  <= '0;
      data_out   <= '0;
      drop_count <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (grant[o]) begin
          valid_out[o] <= 1'b1;
          data_out[o]  <= head[winner[o]];
          rr_ptr[o]    <= (winner[o] == 3'd4) ? 3'd0 : winner[o] + 3'd1;
        end else if (ready_in[o]) begin
          valid_out[o] <= 1'b0;
        end
      end
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule
